// File: rtl/bcd_countdown_pkg.sv
// bcd_countdown_pkg: shared state type, constants and helpers for the BCD countdown timer
package bcd_countdown_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int SEC_W = 14;
    function automatic int tick_w(input int hz);
        return $clog2(hz);
    endfunction
    function automatic logic [3:0] clamp(input logic [3:0] d);
        return d > BCD_MAX ? BCD_MAX : d;
    endfunction
    function automatic logic [SEC_W-1:0] bcd_to_bin(input logic [15:0] b);
        return SEC_W'(b[15:12]) * SEC_W'(1000) + SEC_W'(b[11:8]) * SEC_W'(100)
             + SEC_W'(b[7:4]) * SEC_W'(10) + SEC_W'(b[3:0]);
    endfunction
endpackage

// File: rtl/bcd_countdown_digit.sv
// bcd_digit_dec: one stage of the BCD borrow chain
module bcd_digit_dec import bcd_countdown_pkg::*; (
    input  logic [3:0] d,
    input  logic       borrow_in,
    output logic [3:0] q,
    output logic       borrow_out
);
    assign borrow_out = borrow_in && d == 4'd0;
    assign q = !borrow_in ? d : borrow_out ? BCD_MAX : d - 4'd1;
endmodule

// File: rtl/bcd_countdown.sv
// bcd_countdown: 4-digit BCD seconds countdown with expiry pulse and display outputs.
// Define BCD_COUNTDOWN_AUTORELOAD_EN for periodic reload from the last loaded value.
module bcd_countdown import bcd_countdown_pkg::*; #(
    parameter int CLK_HZ = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [3:0]       ld0,
    input  logic [3:0]       ld1,
    input  logic [3:0]       ld2,
    input  logic [3:0]       ld3,
    input  logic             start,
    input  logic             pause,
    output logic [SEC_W-1:0] sec,
    output logic [3:0]       a0,
    output logic [3:0]       a1,
    output logic [3:0]       a2,
    output logic [3:0]       a3,
    output logic [2:0]       remainder,
    output logic [1:0]       digit,
    output logic             busy,
    output logic             expired
);
    localparam int TW = tick_w(CLK_HZ);
    localparam logic [TW-1:0] TMAX = TW'(CLK_HZ - 1);
    localparam logic [TW-1:0] EIGHTH = TW'(CLK_HZ / 8);
    state_t st, nxt;
    logic [TW-1:0] tick;
    logic [15:0] cur, dec, ld_val, reload_val;
    logic [4:0] br;
    logic is_zero, cnt, step_sec, hit_zero, reload;
    assign cur = {a3, a2, a1, a0};
    assign ld_val = {clamp(ld3), clamp(ld2), clamp(ld1), clamp(ld0)};
    assign br[0] = 1'b1;
    genvar i;
    for (i = 0; i < 4; i++) begin : g_dec
        bcd_digit_dec u_dec (
            .d(cur[4*i +: 4]),
            .borrow_in(br[i]),
            .q(dec[4*i +: 4]),
            .borrow_out(br[i+1])
        );
    end
    // a borrow out of the top digit happens only when every digit is zero
    assign is_zero = br[4];
    assign cnt = busy && !pause;
    assign step_sec = cnt && tick == '0;
    assign hit_zero = step_sec && dec == '0;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    logic [15:0] shadow;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) shadow <= '0;
        else if (load) shadow <= ld_val;
    end
    assign reload = hit_zero && shadow != '0;
    assign reload_val = shadow;
`else
    assign reload = 1'b0;
    assign reload_val = '0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= IDLE;
        else st <= nxt;
    end
    always_comb begin
        nxt = st;
        if (load) nxt = IDLE;
        else begin
            case (st)
                IDLE:       nxt = start ? (is_zero ? DONE : RUN) : IDLE;
                RUN, PAUSE: nxt = pause ? PAUSE : (hit_zero && !reload) ? DONE : RUN;
                default:    nxt = DONE;
            endcase
        end
    end
    always_comb begin
        busy = st == RUN || st == PAUSE;
        digit = a3 != 4'd0 ? 2'd3 : a2 != 4'd0 ? 2'd2 : a1 != 4'd0 ? 2'd1 : 2'd0;
        remainder = 3'(tick / EIGHTH);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick <= TMAX;
            {a3, a2, a1, a0} <= '0;
            sec <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                tick <= TMAX;
                {a3, a2, a1, a0} <= ld_val;
                sec <= bcd_to_bin(ld_val);
            end else if (st == IDLE && start && is_zero) begin
                expired <= 1'b1;
            end else if (cnt) begin
                tick <= step_sec ? TMAX : tick - TW'(1);
                if (step_sec) begin
                    {a3, a2, a1, a0} <= reload ? reload_val : dec;
                    sec <= reload ? bcd_to_bin(reload_val) : sec - SEC_W'(1);
                    expired <= hit_zero;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: table-driven and scoreboard checks of bcd_countdown at CLK_HZ=8
module tb_bcd_countdown;
    localparam int HZ = 8;
    logic clk = 1'b0, rst = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [3:0] ld0 = '0, ld1 = '0, ld2 = '0, ld3 = '0;
    logic [13:0] sec;
    logic [3:0] a0, a1, a2, a3;
    logic [2:0] remainder;
    logic [1:0] digit;
    logic busy, expired;

    bcd_countdown #(.CLK_HZ(HZ)) dut (
        .clk(clk), .rst(rst), .load(load),
        .ld0(ld0), .ld1(ld1), .ld2(ld2), .ld3(ld3),
        .start(start), .pause(pause),
        .sec(sec), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .remainder(remainder), .digit(digit), .busy(busy), .expired(expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ld;
        int          run;
        int          sec;
        logic [15:0] bcd;
        int          dig;
        int          rem;
        logic        busy;
        logic        exp;
    } vec_t;
    typedef struct {
        string nm;
        int    cyc;
    } tm_t;

    vec_t vecs[12];
    vec_t sb[$];
    tm_t  tq[$];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        {ld3, ld2, ld1, ld0} = v;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_exp(output int n);
        int c = 0;
        n = -1;
        while (n < 0 && c < 200) begin
            step(1);
            c++;
            if (expired) n = c;
        end
    endtask

    task automatic expect_expiry(input string nm, input int cyc);
        int n;
        tm_t t;
        tq.push_back('{nm, cyc});
        wait_exp(n);
        t = tq.pop_front();
        chk(t.nm, n, t.cyc);
    endtask

    initial begin
        vec_t v;
        tm_t t;
        int n;
        vecs[0]  = '{16'h0003, 0,  3,    16'h0003, 0, 7, 1'b1, 1'b0};
        vecs[1]  = '{16'h0003, 3,  3,    16'h0003, 0, 4, 1'b1, 1'b0};
        vecs[2]  = '{16'h0003, 7,  3,    16'h0003, 0, 0, 1'b1, 1'b0};
        vecs[3]  = '{16'h0003, 12, 2,    16'h0002, 0, 3, 1'b1, 1'b0};
        vecs[4]  = '{16'h1000, 8,  999,  16'h0999, 2, 7, 1'b1, 1'b0};
        vecs[5]  = '{16'hCCCC, 0,  9999, 16'h9999, 3, 7, 1'b1, 1'b0};
        vecs[6]  = '{16'h0050, 8,  49,   16'h0049, 1, 7, 1'b1, 1'b0};
        vecs[7]  = '{16'h0100, 8,  99,   16'h0099, 1, 7, 1'b1, 1'b0};
        vecs[8]  = '{16'h2000, 16, 1998, 16'h1998, 3, 7, 1'b1, 1'b0};
        vecs[9]  = '{16'h0000, 0,  0,    16'h0000, 0, 7, 1'b0, 1'b1};
        vecs[10] = '{16'h0000, 1,  0,    16'h0000, 0, 7, 1'b0, 1'b0};
        vecs[11] = '{16'h0A0B, 0,  909,  16'h0909, 2, 7, 1'b1, 1'b0};

        step(2);
        chk("rst_sec", sec, 0);
        chk("rst_bcd", {a3, a2, a1, a0}, 0);
        chk("rst_rem", remainder, 7);
        chk("rst_digit", digit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_expired", expired, 0);
        rst = 1'b1;
        step(1);

        foreach (vecs[i]) begin
            sb.push_back(vecs[i]);
            do_load(vecs[i].ld);
            do_start();
            step(vecs[i].run);
            v = sb.pop_front();
            chk($sformatf("v%0d_sec", i), sec, v.sec);
            chk($sformatf("v%0d_bcd", i), {a3, a2, a1, a0}, v.bcd);
            chk($sformatf("v%0d_digit", i), digit, v.dig);
            chk($sformatf("v%0d_rem", i), remainder, v.rem);
            chk($sformatf("v%0d_busy", i), busy, v.busy);
            chk($sformatf("v%0d_expired", i), expired, v.exp);
        end

        // 0003: expiry 24 cycles after start, with second and phase snapshots
        do_load(16'h0003);
        tq.push_back('{"exp_0003", 24});
        do_start();
        n = 0;
        while (n < 100) begin
            step(1);
            n++;
            if (n == 4) chk("t3_rem4", remainder, 3);
            if (n == 8) chk("t3_sec8", sec, 2);
            if (n == 16) chk("t3_sec16", sec, 1);
            if (expired) break;
        end
        t = tq.pop_front();
        chk(t.nm, n, t.cyc);
        chk("t3_sec_end", sec, 0);
`ifndef BCD_COUNTDOWN_AUTORELOAD_EN
        chk("t3_busy_end", busy, 0);
`endif
        step(1);
        chk("t3_pulse_len", expired, 0);

        // pause freezes tick and digits, delaying expiry cycle for cycle
        do_load(16'h0002);
        do_start();
        step(5);
        chk("pz_rem_pre", remainder, 2);
        pause = 1'b1;
        step(5);
        chk("pz_rem_hold", remainder, 2);
        chk("pz_sec_hold", sec, 2);
        chk("pz_busy", busy, 1);
        pause = 1'b0;
        expect_expiry("pz_exp", 11);

        // load together with start wins and leaves the block idle
        do_load(16'h0005);
        do_start();
        step(10);
        {ld3, ld2, ld1, ld0} = 16'h0002;
        load = 1'b1;
        start = 1'b1;
        step(1);
        load = 1'b0;
        start = 1'b0;
        chk("ls_busy", busy, 0);
        chk("ls_sec", sec, 2);
        chk("ls_rem", remainder, 7);
        step(3);
        chk("ls_idle_hold", busy, 0);
        do_start();
        expect_expiry("ls_exp", 16);

        // load on the would-be expiry edge suppresses the pulse
        do_load(16'h0001);
        do_start();
        step(7);
        do_load(16'h0004);
        chk("ml_expired", expired, 0);
        chk("ml_sec", sec, 4);
        chk("ml_busy", busy, 0);

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        do_load(16'h0001);
        do_start();
        for (int k = 0; k < 3; k++) begin
            expect_expiry($sformatf("ar_exp%0d", k), 8);
            chk($sformatf("ar_busy%0d", k), busy, 1);
            chk($sformatf("ar_sec%0d", k), sec, 1);
        end
`else
        do_load(16'h0001);
        do_start();
        expect_expiry("one_exp", 8);
        chk("one_busy", busy, 0);
        step(1);
        chk("one_pulse_len", expired, 0);
        chk("one_sec", sec, 0);
`endif

        // asynchronous reset in the middle of a count
        do_load(16'h0003);
        do_start();
        step(5);
        rst = 1'b0;
        #1;
        chk("ar_rst_sec", sec, 0);
        chk("ar_rst_bcd", {a3, a2, a1, a0}, 0);
        chk("ar_rst_rem", remainder, 7);
        chk("ar_rst_digit", digit, 0);
        chk("ar_rst_busy", busy, 0);
        chk("ar_rst_expired", expired, 0);
        step(1);
        rst = 1'b1;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
